// File: rtl/store_trace_fifo.sv
// store_trace_fifo
// Taps the core store bus and records every aligned store that lands in a
// fixed word window into a small first-word-fall-through FIFO. The tap is
// passive: the store to data memory proceeds regardless of FIFO state.
// Stores that arrive while the FIFO is full (and nothing is leaving) are
// dropped and accounted for in sticky/saturating status registers.

module store_trace_fifo #(
  parameter logic [31:0] BASE_ADDR    = 32'd100,
  parameter int unsigned WINDOW_WORDS = 4,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  output logic                     misaligned,
  input  logic                     clear
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Window bounds carried at 33 bits so a window near the top of the
  // address space does not wrap back to low addresses.
  localparam logic [32:0]   WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [32:0]   WIN_HI   = WIN_LO + 33'(4 * WINDOW_WORDS);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [63:0]   mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          misaligned_q, misaligned_d;

  logic [32:0]   adr_ext;
  logic          hit;
  logic          aligned;
  logic          push;
  logic          mis_hit;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr_en;
  logic          drop;

  assign adr_ext = {1'b0, DataAdr};
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);

  // Store qualification and FIFO handshake decode.
  always_comb begin
    hit     = MemWrite && (adr_ext >= WIN_LO) && (adr_ext < WIN_HI);
    aligned = (DataAdr[1:0] == 2'b00);
    push    = hit && aligned;
    mis_hit = hit && !aligned;
    pop     = !empty && out_ready;
    // A pop in the same cycle frees the slot the push needs, so a full
    // FIFO can still accept the store.
    wr_en   = push && (!full || pop);
    drop    = push && full && !pop;
  end

  // Next-state for pointers, occupancy and status; a new event outranks clear.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CW'(wr_en) - CW'(pop);
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    misaligned_d = misaligned_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (clear) begin
      overflow_d   = 1'b0;
      drop_cnt_d   = 8'd0;
      misaligned_d = 1'b0;
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (clear) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    if (mis_hit) begin
      misaligned_d = 1'b1;
    end
  end

  // State registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= 8'd0;
      misaligned_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Record storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {DataAdr, WriteData};
    end
  end

  assign out_valid  = !empty;
  assign out_addr   = mem_q[rd_ptr_q][63:32];
  assign out_data   = mem_q[rd_ptr_q][31:0];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;
  assign misaligned = misaligned_q;

endmodule
